// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) arithmetic, state typedef and ShiftRows index map.
package aes_pkg;

  // Low byte of the 0x11B reduction polynomial.
  localparam logic [7:0] AES_POLY = 8'h1B;

  // State as 16 bytes; index 0 is the most significant byte of the 128-bit vector.
  typedef logic [7:0] aes_state_t [16];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gmul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  // Source byte index for ShiftRows output byte idx = 4c+r: 4*((c+r)%4)+r.
  // The 2-bit column add wraps mod 4 by construction.
  function automatic logic [3:0] sr_src(input logic [3:0] idx);
    logic [1:0] r;
    logic [1:0] c;
    r = idx[1:0];
    c = idx[3:2] + r;
    return {c, r};
  endfunction

endpackage

// File: rtl/mix_column.sv
// Combinational MixColumns on one 32-bit column; row 0 byte is col_i[31:24].
module mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  // Matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2] applied to the column.
  always_comb begin
    col_o[31:24] = gmul2(a0) ^ gmul3(a1) ^ a2        ^ a3;
    col_o[23:16] = a0        ^ gmul2(a1) ^ gmul3(a2) ^ a3;
    col_o[15:8]  = a0        ^ a1        ^ gmul2(a2) ^ gmul3(a3);
    col_o[7:0]   = gmul3(a0) ^ a1        ^ a2        ^ gmul2(a3);
  end

endmodule

// File: rtl/aes_round_tail.sv
// AES round back-end: ShiftRows, optional MixColumns, AddRoundKey, then a
// 2-entry valid/ready output buffer.
module aes_round_tail
  import aes_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_state,
  input  logic [127:0]     in_key,
  input  logic             in_last,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_state,
  output logic [TAG_W-1:0] out_tag
);

  aes_state_t   in_b;
  aes_state_t   sr_b;
  logic [127:0] sr;
  logic [127:0] mc;
  logic [127:0] result;

  // ShiftRows as a pure byte permutation.
  always_comb begin
    sr = '0;
    for (int i = 0; i < 16; i++) begin
      in_b[i] = in_state[8*(15-i) +: 8];
    end
    for (int i = 0; i < 16; i++) begin
      sr_b[i] = in_b[sr_src(4'(i))];
      sr[8*(15-i) +: 8] = sr_b[i];
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    mix_column u_mix_column (
      .col_i(sr[32*(3-c) +: 32]),
      .col_o(mc[32*(3-c) +: 32])
    );
  end

  assign result = (in_last ? sr : mc) ^ in_key;

  // Output buffer state.
  logic [127:0]     data_q [2];
  logic [127:0]     data_d [2];
  logic [TAG_W-1:0] tag_q  [2];
  logic [TAG_W-1:0] tag_d  [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push, pop;
  logic             head_idx;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // When empty, show the entry just behind the read pointer: the last popped
  // head, or the reset zero.
  assign head_idx  = (count_q == 2'd0) ? ~rd_ptr_q : rd_ptr_q;
  assign out_state = data_q[head_idx];
  assign out_tag   = tag_q[head_idx];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    data_d   = data_q;
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q;
    if (push) begin
      data_d[wr_ptr_q] = result;
      tag_d[wr_ptr_q]  = in_tag;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Buffer registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '{default: '0};
      tag_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      data_q   <= data_d;
      tag_q    <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_aes_round_tail.sv
// Self-checking bench for aes_round_tail with a byte-level reference model.
module tb_aes_round_tail;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_state;
  logic [127:0]     in_key;
  logic             in_last;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_state;
  logic [TAG_W-1:0] out_tag;

  int checks = 0;
  int errors = 0;

  logic [127:0]     exp_s [$];
  logic [TAG_W-1:0] exp_t [$];
  logic [TAG_W-1:0] pop_log [$];

  aes_round_tail #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_key(in_key), .in_last(in_last), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_state(out_state), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", name, got, exp, $time);
    end
  endtask

  // General shift-and-add multiply in GF(2^8) mod x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    logic       hi;
    p = 8'h00; aa = a; bb = b;
    for (int n = 0; n < 8; n++) begin
      if (bb[0]) p = p ^ aa;
      hi = aa[7];
      aa = {aa[6:0], 1'b0};
      if (hi) aa = aa ^ 8'h1b;
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   a [16];
    logic [7:0]   t [16];
    logic [7:0]   o [16];
    logic [7:0]   coef;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        t[4*c+rr] = a[4*((c+rr)%4)+rr];
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) begin
        if (last) begin
          o[4*c+rr] = t[4*c+rr];
        end else begin
          o[4*c+rr] = 8'h00;
          for (int j = 0; j < 4; j++) begin
            coef = (j == rr) ? 8'd2 : (j == (rr+1)%4) ? 8'd3 : 8'd1;
            o[4*c+rr] = o[4*c+rr] ^ gf_mul(coef, t[4*c+j]);
          end
        end
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = o[i] ^ k[127-8*i -: 8];
    return r;
  endfunction

  // Compare process: outputs are stable at the falling edge; the model then
  // applies what the coming rising edge will do.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_s.delete();
      exp_t.delete();
    end else begin
      chk("mon_out_valid", {127'd0, out_valid}, {127'd0, exp_s.size() != 0});
      chk("mon_in_ready", {127'd0, in_ready}, {127'd0, exp_s.size() < 2});
      if (exp_s.size() != 0) begin
        chk("mon_out_state", out_state, exp_s[0]);
        chk("mon_out_tag", {124'd0, out_tag}, {124'd0, exp_t[0]});
      end
      if (out_valid && out_ready) begin
        pop_log.push_back(out_tag);
        if (exp_s.size() != 0) begin
          void'(exp_s.pop_front());
          void'(exp_t.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_s.push_back(ref_round(in_state, in_key, in_last));
        exp_t.push_back(in_tag);
      end
    end
  end

  // Present a beat and return one time unit after the edge that accepts it.
  task automatic send(input logic [127:0] s, input logic [127:0] k, input logic l,
                      input logic [TAG_W-1:0] t);
    int n;
    in_state = s; in_key = k; in_last = l; in_tag = t; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got in_ready 0 exp 1 at %0t", $time);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_done", {127'd0, out_valid}, 128'd0);
  endtask

  localparam logic [127:0] FipsIn  = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
  localparam logic [127:0] FipsKey = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] FipsOut = 128'ha49c7ff2_689f352b_6b5bea43_026a5049;
  localparam logic [127:0] SeqIn   = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] SeqOut  = 128'h00050a0f_04090e03_080d0207_0c01060b;
  localparam logic [127:0] ColIn   = 128'hdb000000_00130000_00005300_00000045;
  localparam logic [127:0] ColOut  = 128'h8e4da1bc_00000000_00000000_00000000;

  initial begin
    logic [127:0] s, k;
    rst_n = 1'b0; in_valid = 1'b0; in_state = '0; in_key = '0; in_last = 1'b0;
    in_tag = '0; out_ready = 1'b0;
    #1;
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_out_state", out_state, 128'd0);
    chk("rst_out_tag", {124'd0, out_tag}, 128'd0);

    // Pin the reference model to the published vectors.
    chk("model_fips", ref_round(FipsIn, FipsKey, 1'b0), FipsOut);
    chk("model_bypass", ref_round(SeqIn, 128'd0, 1'b1), SeqOut);
    chk("model_column", ref_round(ColIn, 128'd0, 1'b0), ColOut);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, one-cycle latency.
    out_ready = 1'b1;
    send(FipsIn, FipsKey, 1'b0, 4'd5);
    in_valid = 1'b0;
    chk("fips_valid", {127'd0, out_valid}, 128'd1);
    chk("fips_state", out_state, FipsOut);
    chk("fips_tag", {124'd0, out_tag}, 128'd5);
    send(SeqIn, 128'd0, 1'b1, 4'd6);
    in_valid = 1'b0;
    chk("bypass_state", out_state, SeqOut);
    send(ColIn, 128'd0, 1'b0, 4'd7);
    in_valid = 1'b0;
    chk("column_state", out_state, ColOut);
    drain();

    // Backpressure: two beats absorbed, third stalls until space frees.
    out_ready = 1'b0;
    pop_log.delete();
    send(128'h11, 128'h22, 1'b0, 4'd1);
    send(128'h33, 128'h44, 1'b1, 4'd2);
    in_state = 128'h55; in_key = 128'h66; in_last = 1'b0; in_tag = 4'd3; in_valid = 1'b1;
    chk("bp_full", {127'd0, in_ready}, 128'd0);
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      chk("bp_stall", {127'd0, in_ready}, 128'd0);
      chk("bp_head_tag", {124'd0, out_tag}, 128'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_ready_back", {127'd0, in_ready}, 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    chk("bp_count", 128'(pop_log.size()), 128'd3);
    for (int n = 0; n < 3; n++) begin
      if (n < pop_log.size()) chk("bp_order", {124'd0, pop_log[n]}, 128'(n + 1));
    end

    // Streaming at full rate.
    pop_log.delete();
    for (int n = 0; n < 20; n++) begin
      in_state = {$urandom, $urandom, $urandom, $urandom};
      in_key   = {$urandom, $urandom, $urandom, $urandom};
      in_last  = 1'($urandom_range(0, 1));
      in_tag   = 4'(n);
      in_valid = 1'b1;
      chk("stream_in_ready", {127'd0, in_ready}, 128'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    chk("stream_count", 128'(pop_log.size()), 128'd20);

    // Reset with the buffer full.
    out_ready = 1'b0;
    send(128'haa, 128'hbb, 1'b0, 4'd8);
    send(128'hcc, 128'hdd, 1'b0, 4'd9);
    in_valid = 1'b0;
    chk("rf_full", {127'd0, in_ready}, 128'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rf_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rf_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rf_out_state", out_state, 128'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rf_idle", {127'd0, out_valid}, 128'd0);
    out_ready = 1'b1;
    s = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    send(s, k, 1'b0, 4'd10);
    in_valid = 1'b0;
    chk("rf_first_tag", {124'd0, out_tag}, 128'd10);
    chk("rf_first_state", out_state, ref_round(s, k, 1'b0));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
